// File: rtl/fifo_stream_read_adapter_if.sv
// fifo_stream_read_adapter_if: valid/ready stream carrying the adapter's output words
interface fifo_stream_read_adapter_if #(parameter int DATA_WIDTH = 16);
  logic [DATA_WIDTH-1:0] stream_data;
  logic stream_valid;
  logic stream_ready;
  modport master (output stream_data, stream_valid, input stream_ready);
  modport slave (input stream_data, stream_valid, output stream_ready);
endinterface

// File: rtl/fifo_stream_read_adapter.sv
// fifo_stream_read_adapter: FIFO read port to valid/ready stream via credit-limited skid buffer; FIFO_STREAM_ADAPTER_STATS_EN adds words_transferred
module fifo_stream_read_adapter #(
  parameter int DATA_WIDTH = 16,
  parameter int READ_LATENCY = 1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic fifo_read_data_valid,
  output logic fifo_read_enable,
  input  logic flush,
  fifo_stream_read_adapter_if.master stream,
  output logic protocol_error
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
  ,
  output logic [31:0] words_transferred
`endif
);
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + READ_LATENCY + 2) + 1;
  logic [CW-1:0] in_flight_q, in_flight_d, count_q, count_d, discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic protocol_error_q;
  logic ret, returned, push, pop;
  assign fifo_read_enable = !reset && !fifo_empty && !flush && (in_flight_q + count_q < CW'(BUFFER_DEPTH));
  assign ret = fifo_read_data_valid;
  assign returned = ret && in_flight_q != '0;
  assign push = ret && discard_q == '0 && !flush;
  assign stream.stream_valid = count_q != '0 && !flush;
  assign stream.stream_data = mem_q[rd_ptr_q];
  assign pop = stream.stream_valid && stream.stream_ready;
  assign protocol_error = protocol_error_q;
  // next state of credit, occupancy, discard and pointer bookkeeping
  always_comb begin
    in_flight_d = in_flight_q + CW'(fifo_read_enable) - CW'(returned);
    discard_d = flush ? in_flight_q - CW'(returned) : discard_q - CW'(ret && discard_q != '0);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
  end
  // state registers, skid buffer storage and sticky protocol error
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight_q <= '0;
      count_q <= '0;
      discard_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      protocol_error_q <= 1'b0;
      for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      count_q <= count_d;
      discard_q <= discard_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      protocol_error_q <= protocol_error_q || (ret && in_flight_q == '0);
      if (push) mem_q[wr_ptr_q] <= fifo_read_data;
    end
  end
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
  logic [31:0] words_transferred_q;
  assign words_transferred = words_transferred_q;
  // count accepted output words, wrapping naturally; flush leaves it alone
  always_ff @(posedge clock) begin
    if (reset) words_transferred_q <= '0;
    else words_transferred_q <= words_transferred_q + 32'(pop);
  end
`endif
endmodule

// File: tb/tb_fifo_stream_read_adapter.sv
// tb_fifo_stream_read_adapter: scoreboard bench running READ_LATENCY 1 and 2 lanes side by side
module tb_fifo_stream_read_adapter;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  int checks = 0;
  int failures = 0;
  int lanes_done = 0;
  always #5 clock = ~clock;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int RL = g + 1;
    logic reset, fifo_empty, fifo_read_enable, fifo_read_data_valid, flush, force_v, protocol_error;
    logic [DW-1:0] fifo_read_data;
    logic pv [RL];
    logic [DW-1:0] pd [RL];
    logic [DW-1:0] fq [$];
    logic [DW-1:0] exp_q [$];
    logic prev_stall;
    logic [DW-1:0] prev_data;
    int issued, returned, pops, n, p0, iss0, ret0, occ, max_occ;
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] words_transferred;
`endif
    fifo_stream_read_adapter_if #(.DATA_WIDTH(DW)) s ();
    assign fifo_read_data_valid = pv[RL-1] | force_v;
    assign fifo_read_data = pd[RL-1];
    fifo_stream_read_adapter #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .BUFFER_DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .fifo_empty(fifo_empty),
      .fifo_read_data(fifo_read_data),
      .fifo_read_data_valid(fifo_read_data_valid),
      .fifo_read_enable(fifo_read_enable),
      .flush(flush),
      .stream(s.master),
      .protocol_error(protocol_error)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
      ,
      .words_transferred(words_transferred)
`endif
    );
    // FIFO read-side model: registered empty, data returns RL cycles after read_enable
    always @(posedge clock) begin
      if (reset) begin
        fq.delete();
        fifo_empty <= 1'b1;
        issued <= 0;
        returned <= 0;
        for (int i = 0; i < RL; i++) begin
          pv[i] <= 1'b0;
          pd[i] <= '0;
        end
      end else begin
        if (fifo_read_enable) begin
          pd[0] <= fq.pop_front();
          issued <= issued + 1;
        end else pd[0] <= '0;
        if (pv[RL-1]) returned <= returned + 1;
        pv[0] <= fifo_read_enable;
        for (int i = 1; i < RL; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
        fifo_empty <= fq.size() == 0;
      end
    end
    // output monitor: scoreboard compare on handshake, stability while stalled
    always @(negedge clock) begin
      if (reset) begin
        pops <= 0;
        prev_stall <= 1'b0;
      end else begin
        if (s.stream_valid && s.stream_ready) begin
          if (exp_q.size() != 0) check($sformatf("L%0d data", g), s.stream_data, exp_q.pop_front());
          else check($sformatf("L%0d extra_word", g), exp_q.size(), 1);
          pops <= pops + 1;
        end
        if (prev_stall && s.stream_valid) check($sformatf("L%0d stable", g), s.stream_data, prev_data);
        prev_stall <= s.stream_valid && !s.stream_ready;
        prev_data <= s.stream_data;
      end
    end
    initial begin
      reset = 1'b1;
      flush = 1'b0;
      force_v = 1'b0;
      s.stream_ready = 1'b0;
      tick(3);
      check($sformatf("L%0d rden_in_reset", g), fifo_read_enable, 0);
      reset = 1'b0;
      tick();
      check($sformatf("L%0d rst_valid", g), s.stream_valid, 0);
      check($sformatf("L%0d rst_data", g), s.stream_data, 0);
      check($sformatf("L%0d rst_perr", g), protocol_error, 0);
      check($sformatf("L%0d rst_rden", g), fifo_read_enable, 0);
      s.stream_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
        fq.push_back(DW'(i));
        exp_q.push_back(DW'(i));
      end
      n = 0;
      while (fifo_empty && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("L%0d empty_fell", g), fifo_empty, 0);
      n = 0;
      while (!s.stream_valid && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("L%0d first_latency", g), n, RL + 1);
      p0 = pops;
      tick(8);
      check($sformatf("L%0d burst8", g), pops - p0, 8);
      check($sformatf("L%0d burst8_left", g), exp_q.size(), 0);
      s.stream_ready = 1'b0;
      iss0 = issued;
      for (int i = 0; i < 20; i++) begin
        fq.push_back(DW'(16'h0100 + i));
        exp_q.push_back(DW'(16'h0100 + i));
      end
      tick(10);
      check($sformatf("L%0d bp_issues", g), issued - iss0, DEPTH);
      check($sformatf("L%0d bp_rden_low", g), fifo_read_enable, 0);
      check($sformatf("L%0d bp_valid", g), s.stream_valid, 1);
      s.stream_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        tick();
        n++;
      end
      check($sformatf("L%0d bp_no_gaps", g), n, 20);
      for (int i = 0; i < 1000; i++) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        fq.push_back(w);
        exp_q.push_back(w);
      end
      n = 0;
      max_occ = 0;
      while (exp_q.size() != 0 && n < 20000) begin
        s.stream_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
        occ = returned - pops;
        if (occ > max_occ) max_occ = occ;
      end
      check($sformatf("L%0d rand_drained", g), exp_q.size(), 0);
      check($sformatf("L%0d rand_no_overflow", g), max_occ <= DEPTH, 1);
      check($sformatf("L%0d rand_perr", g), protocol_error, 0);
      s.stream_ready = 1'b0;
      tick(2);
      iss0 = issued;
      ret0 = returned;
      fq.push_back(16'h0011);
      fq.push_back(16'h0022);
      fq.push_back(16'h0033);
      n = 0;
      while (!(issued - iss0 == 3 && returned - ret0 == 2) && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("L%0d flush_inflight", g), fifo_read_data_valid, 1);
      check($sformatf("L%0d flush_buffered", g), s.stream_valid, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check($sformatf("L%0d flush_valid_low", g), s.stream_valid, 0);
      fq.push_back(16'h00AA);
      exp_q.push_back(16'h00AA);
      s.stream_ready = 1'b1;
      p0 = pops;
      tick(RL + 8);
      check($sformatf("L%0d flush_aa_only", g), pops - p0, 1);
      check($sformatf("L%0d flush_aa_left", g), exp_q.size(), 0);
      s.stream_ready = 1'b0;
      iss0 = issued;
      fq.push_back(16'h0044);
      fq.push_back(16'h0055);
      fq.push_back(16'h0066);
      exp_q.push_back(16'h0055);
      exp_q.push_back(16'h0066);
      n = 0;
      while (issued - iss0 != 1 && n < 20) begin
        tick();
        n++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      s.stream_ready = 1'b1;
      p0 = pops;
      tick(RL + 10);
      check($sformatf("L%0d flush2_count", g), pops - p0, 2);
      check($sformatf("L%0d flush2_left", g), exp_q.size(), 0);
      s.stream_ready = 1'b0;
      tick(2);
      force_v = 1'b1;
      tick();
      force_v = 1'b0;
      check($sformatf("L%0d perr_set", g), protocol_error, 1);
      tick(5);
      check($sformatf("L%0d perr_held", g), protocol_error, 1);
      reset = 1'b1;
      tick(2);
      check($sformatf("L%0d rden_in_reset2", g), fifo_read_enable, 0);
      exp_q.delete();
      reset = 1'b0;
      tick();
      check($sformatf("L%0d perr_cleared", g), protocol_error, 0);
      check($sformatf("L%0d rst2_valid", g), s.stream_valid, 0);
      check($sformatf("L%0d rst2_data", g), s.stream_data, 0);
      for (int i = 0; i < 300; i++) begin
        fq.push_back(DW'(16'h2000 + i));
        exp_q.push_back(DW'(16'h2000 + i));
      end
      s.stream_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
        tick();
        n++;
      end
      check($sformatf("L%0d w300_drained", g), exp_q.size(), 0);
      check($sformatf("L%0d w300_pops", g), pops, 300);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
      check($sformatf("L%0d stats_300", g), words_transferred, 300);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      check($sformatf("L%0d stats_reset", g), words_transferred, 0);
`endif
      lanes_done++;
    end
  end
  initial begin
    for (int i = 0; i < 60000 && lanes_done < 2; i++) @(posedge clock);
    if (lanes_done < 2) check("timeout", lanes_done, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
